// File: rtl/fp16_addsub_array.sv
// N-lane IEEE binary16 add/subtract with per-lane valid/ready pipelines.
// Stage 0 registers operands, stage 1 holds the rounded result, the rest retime.
module fp16_addsub_array #(
    parameter int N   = 4,
    parameter int LAT = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_tvalid,
    output logic [N-1:0]   in_tready,
    input  logic [N-1:0]   op_sub,
    input  logic [N*16-1:0] add_in_A_flat,
    input  logic [N*16-1:0] add_in_B_flat,
    output logic [N-1:0]   out_tvalid,
    input  logic [N-1:0]   out_tready,
    output logic [N*16-1:0] add_out_flat,
    output logic [N*2-1:0] out_flags
);

    // Returns {invalid, overflow, result}; b already carries the effective sign.
    function automatic logic [17:0] f_addsub(input logic [15:0] a, input logic [15:0] b);
        logic               nan_a, nan_b, inf_a, inf_b;
        logic [14:0]        mag_a, mag_b, mag_x, mag_y;
        logic               swap, s_x, s_y, eff_sub, rnd;
        logic [4:0]         d, dd;
        logic [24:0]        t;
        logic [13:0]        m_x, m_y, nrm;
        logic [14:0]        sum;
        logic [3:0]         lz;
        logic signed [6:0]  e_r;
        logic [11:0]        sig_r;
        logic [9:0]         man;
        logic [17:0]        res;
        nan_a = (&a[14:10]) & (|a[9:0]);
        nan_b = (&b[14:10]) & (|b[9:0]);
        inf_a = (&a[14:10]) & ~(|a[9:0]);
        inf_b = (&b[14:10]) & ~(|b[9:0]);
        mag_a = (a[14:10] == 5'd0) ? 15'd0 : a[14:0];
        mag_b = (b[14:10] == 5'd0) ? 15'd0 : b[14:0];
        swap  = mag_b > mag_a;
        mag_x = swap ? mag_b : mag_a;
        mag_y = swap ? mag_a : mag_b;
        s_x   = swap ? b[15] : a[15];
        s_y   = swap ? a[15] : b[15];
        eff_sub = s_x ^ s_y;
        m_x = {|mag_x[14:10], mag_x[9:0], 3'b000};
        d   = mag_x[14:10] - mag_y[14:10];
        dd  = (d > 5'd14) ? 5'd14 : d;
        // Shifted-out bits collapse into the sticky position.
        t   = {|mag_y[14:10], mag_y[9:0], 14'b0} >> dd;
        m_y = {t[24:12], t[11] | (|t[10:0])};
        sum = eff_sub ? ({1'b0, m_x} - {1'b0, m_y}) : ({1'b0, m_x} + {1'b0, m_y});
        lz  = 4'd0;
        for (int k = 0; k < 14; k++) begin
            if (sum[k]) lz = 4'(13 - k);
        end
        if (sum[14]) begin
            nrm = {sum[14:2], sum[1] | sum[0]};
            e_r = 7'(mag_x[14:10]) + 7'd1;
        end else begin
            nrm = sum[13:0] << lz;
            e_r = 7'(mag_x[14:10]) - 7'(lz);
        end
        rnd   = nrm[2] & ((|nrm[1:0]) | nrm[3]);
        sig_r = {1'b0, nrm[13:3]} + 12'(rnd);
        if (sig_r[11]) begin
            man = sig_r[10:1];
            e_r = e_r + 7'd1;
        end else begin
            man = sig_r[9:0];
        end
        res = 18'd0;
        if (nan_a || nan_b) begin
            res = {2'b10, 16'h7E00};
        end else if (inf_a && inf_b) begin
            res = (a[15] ^ b[15]) ? {2'b10, 16'h7E00} : {2'b00, a};
        end else if (inf_a) begin
            res = {2'b00, a};
        end else if (inf_b) begin
            res = {2'b00, b};
        end else if (mag_x == 15'd0) begin
            res = {2'b00, a[15] & b[15], 15'd0};
        end else if (sum == 15'd0) begin
            res = 18'd0;
        end else if (e_r >= 7'sd31) begin
            res = {2'b01, s_x, 15'h7C00};
        end else if (e_r <= 7'sd0) begin
            res = {2'b00, s_x, 15'd0};
        end else begin
            res = {2'b00, s_x, e_r[4:0], man};
        end
        return res;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [LAT-1:0] r_v;
        logic [31:0]    r_ops;
        logic [17:0]    r_res [1:LAT-1];
        logic           w_stall;
        logic [15:0]    w_b;
        logic [17:0]    w_res;

        assign w_stall = r_v[LAT-1] & ~out_tready[i];
        assign w_b     = {add_in_B_flat[i*16+15] ^ op_sub[i], add_in_B_flat[i*16 +: 15]};
        assign w_res   = f_addsub(r_ops[31:16], r_ops[15:0]);

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_v   <= '0;
                r_ops <= '0;
                for (int s = 1; s < LAT; s++) r_res[s] <= '0;
            end else if (!w_stall) begin
                r_v      <= {r_v[LAT-2:0], in_tvalid[i]};
                r_ops    <= {add_in_A_flat[i*16 +: 16], w_b};
                r_res[1] <= w_res;
                for (int s = 2; s < LAT; s++) r_res[s] <= r_res[s-1];
            end
        end

        assign in_tready[i]           = ~w_stall;
        assign out_tvalid[i]          = r_v[LAT-1];
        assign add_out_flat[i*16 +: 16] = r_res[LAT-1][15:0];
        assign out_flags[i*2 +: 2]    = r_v[LAT-1] ? r_res[LAT-1][17:16] : 2'b00;
    end

endmodule

// File: tb/tb_fp16_addsub_array.sv
// Bench for fp16_addsub_array: three instances (LAT 2, 3, 6) share stimulus
// and are scored against a real-arithmetic binary16 reference.
module tb_fp16_addsub_array;
    localparam int N  = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   tready;
    logic [N-1:0]   vin    [ND];
    logic [N-1:0]   op     [ND];
    logic [N*16-1:0] a_fl  [ND];
    logic [N*16-1:0] b_fl  [ND];
    logic [N-1:0]   irdy   [ND];
    logic [N-1:0]   vout   [ND];
    logic [N*16-1:0] res_fl [ND];
    logic [N*2-1:0] flg_fl [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        fp16_addsub_array #(.N(N), .LAT(g == 0 ? 2 : (g == 1 ? 3 : 6))) u_dut (
            .clk(clk), .rst(rst),
            .in_tvalid(vin[g]), .in_tready(irdy[g]), .op_sub(op[g]),
            .add_in_A_flat(a_fl[g]), .add_in_B_flat(b_fl[g]),
            .out_tvalid(vout[g]), .out_tready(tready),
            .add_out_flat(res_fl[g]), .out_flags(flg_fl[g])
        );
    end

    typedef struct { logic [17:0] r; int ca; } ent_t;
    ent_t q [ND][N][$];
    logic seen [ND][N];
    int   ptr  [ND][N];
    int   nb   [N];
    logic [15:0] sa  [N][64];
    logic [15:0] sb  [N][64];
    logic        sop [N][64];
    logic [N-1:0] strict;
    logic mon_en = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int d);
        return d == 0 ? 2 : (d == 1 ? 3 : 6);
    endfunction

    function automatic real pow2(int e);
        real r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else repeat (-e) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_val(logic [15:0] h);
        real v;
        if (h[14:10] == 5'd0) return 0.0;
        v = (1024.0 + real'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -v : v;
    endfunction

    // Reference: exact sum in double precision, then RNE to binary16 with FTZ.
    function automatic logic [17:0] ref_op(logic [15:0] a, logic [15:0] b, logic sub);
        logic [15:0] bb;
        logic na, nbn, ia, ib, s;
        real sum, m, fr;
        int e, f;
        bb  = {b[15] ^ sub, b[14:0]};
        na  = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        nbn = (bb[14:10] == 5'h1F) && (bb[9:0] != 0);
        ia  = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        ib  = (bb[14:10] == 5'h1F) && (bb[9:0] == 0);
        if (na || nbn) return {2'b10, 16'h7E00};
        if (ia && ib) return (a[15] != bb[15]) ? {2'b10, 16'h7E00} : {2'b00, a};
        if (ia) return {2'b00, a};
        if (ib) return {2'b00, bb};
        if (a[14:10] == 0 && bb[14:10] == 0) return {2'b00, a[15] & bb[15], 15'd0};
        sum = fp_val(a) + fp_val(bb);
        if (sum == 0.0) return 18'd0;
        s = sum < 0.0;
        if (s) sum = -sum;
        e = 0;
        while (sum >= pow2(e + 1)) e++;
        while (sum < pow2(e)) e--;
        if (e < -14) return {2'b00, s, 15'd0};
        m  = sum / pow2(e - 10);
        f  = $rtoi(m);
        fr = m - real'(f);
        if (fr > 0.5 || (fr == 0.5 && (f % 2) == 1)) f++;
        if (f == 2048) begin
            f = 1024;
            e++;
        end
        if (e > 15) return {2'b01, s, 15'h7C00};
        return {2'b00, s, 5'(e + 15), 10'(f - 1024)};
    endfunction

    function automatic logic [15:0] rnd_fp();
        case ($urandom_range(0, 14))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            4: return 16'h7E00;
            5: return 16'h7BFF;
            6: return 16'h0001;
            7: return 16'h0400;
            8: return 16'h3C00;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        logic v, e1;
        int lt;
        ent_t e;
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                for (int i = 0; i < N; i++) begin
                    v  = vout[d][i];
                    e1 = ~(v & ~tready[i]);
                    chk($sformatf("in_tready L%0d lane%0d", lat_of(d), i), irdy[d][i], e1);
                    if (!v) begin
                        chk($sformatf("idle flags L%0d lane%0d", lat_of(d), i),
                            flg_fl[d][i*2 +: 2], 0);
                    end else if (q[d][i].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious L%0d lane%0d: got %h expected no beat",
                                 lat_of(d), i, res_fl[d][i*16 +: 16]);
                    end else begin
                        chk($sformatf("result L%0d lane%0d", lat_of(d), i),
                            {flg_fl[d][i*2 +: 2], res_fl[d][i*16 +: 16]}, q[d][i][0].r);
                        if (!seen[d][i]) begin
                            seen[d][i] = 1'b1;
                            lt = cyc - q[d][i][0].ca - (lat_of(d) - 1);
                            if (strict[i]) begin
                                chk($sformatf("latency L%0d lane%0d", lat_of(d), i), lt, 0);
                            end else begin
                                n_cmp++;
                                if (lt < 0) begin
                                    n_bad++;
                                    $display("FAIL early L%0d lane%0d: got %0d expected >=0",
                                             lat_of(d), i, lt);
                                end
                            end
                        end
                        if (tready[i]) begin
                            void'(q[d][i].pop_front());
                            seen[d][i] = 1'b0;
                        end
                    end
                    if (rst && vin[d][i] && irdy[d][i]) begin
                        e.r  = ref_op(a_fl[d][i*16 +: 16], b_fl[d][i*16 +: 16], op[d][i]);
                        e.ca = cyc + 1;
                        q[d][i].push_back(e);
                        ptr[d][i]++;
                    end
                end
            end
            if (!rst) begin
                for (int d = 0; d < ND; d++)
                    for (int i = 0; i < N; i++) begin
                        q[d][i].delete();
                        seen[d][i] = 1'b0;
                    end
            end
        end
    end

    task automatic drive_idle();
        for (int d = 0; d < ND; d++) begin
            vin[d]  = '0;
            op[d]   = '0;
            a_fl[d] = '0;
            b_fl[d] = '0;
        end
        tready = '1;
    endtask

    // mode 0: ready high; 1: random ready; 2: lane 2 ready low in cycles 5-9.
    task automatic run_phase(int mode, int bub, logic [N-1:0] strict_m, int budget);
        logic [N-1:0] gate;
        bit done;
        strict = strict_m;
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < N; i++) ptr[d][i] = 0;
        done = 0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            done = 1;
            for (int d = 0; d < ND; d++)
                for (int i = 0; i < N; i++)
                    if (ptr[d][i] < nb[i] || q[d][i].size() != 0) done = 0;
            if (done) break;
            for (int i = 0; i < N; i++) gate[i] = $urandom_range(0, 99) >= bub;
            case (mode)
                1: for (int i = 0; i < N; i++) tready[i] = $urandom_range(0, 3) != 0;
                2: tready = (k >= 5 && k <= 9) ? 4'b1011 : 4'b1111;
                default: tready = '1;
            endcase
            for (int d = 0; d < ND; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (ptr[d][i] < nb[i] && gate[i]) begin
                        vin[d][i] = 1'b1;
                        a_fl[d][i*16 +: 16] = sa[i][ptr[d][i]];
                        b_fl[d][i*16 +: 16] = sb[i][ptr[d][i]];
                        op[d][i] = sop[i][ptr[d][i]];
                    end else begin
                        vin[d][i] = 1'b0;
                        a_fl[d][i*16 +: 16] = 16'($urandom);
                        b_fl[d][i*16 +: 16] = 16'($urandom);
                        op[d][i] = 1'($urandom);
                    end
                end
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL phase timeout: got pending beats expected drained in %0d cycles", budget);
        end
        drive_idle();
    endtask

    task automatic load_random(int n);
        for (int i = 0; i < N; i++) begin
            nb[i] = n;
            for (int j = 0; j < n; j++) begin
                sa[i][j] = rnd_fp();
                sb[i][j] = ($urandom_range(0, 9) < 3) ?
                           (sa[i][j] ^ 16'($urandom_range(0, 3))) : rnd_fp();
                sop[i][j] = 1'($urandom);
            end
        end
    endtask

    task automatic chk_reset_state(string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s out_tvalid L%0d", tag, lat_of(d)), vout[d], 0);
            chk($sformatf("%s out_flags L%0d", tag, lat_of(d)), flg_fl[d], 0);
            chk($sformatf("%s add_out L%0d", tag, lat_of(d)), res_fl[d], 0);
            chk($sformatf("%s in_tready L%0d", tag, lat_of(d)), irdy[d], 4'hF);
        end
    endtask

    logic [15:0] dv_a [16];
    logic [15:0] dv_b [16];
    logic        dv_o [16];
    logic [17:0] dv_e [16];

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        dv_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4200, 16'h3C00, 16'h3C00, 16'h3C01,
                 16'h7BFF, 16'h7C00, 16'h7E00, 16'h0001, 16'h8000, 16'h0000, 16'hFC00, 16'h7C00};
        dv_b = '{16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3800, 16'h3C00, 16'h1000, 16'h1000,
                 16'h7BFF, 16'h7C00, 16'h3C00, 16'h0000, 16'h8000, 16'h8000, 16'h7C00, 16'h3C00};
        dv_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        dv_e = '{18'h03E00, 18'h04100, 18'h04300, 18'h04480, 18'h04100, 18'h00000, 18'h03C00,
                 18'h03C02, 18'h17C00, 18'h27E00, 18'h27E00, 18'h00000, 18'h08000, 18'h00000,
                 18'h0FC00, 18'h07C00};
        for (int k = 0; k < 16; k++)
            chk($sformatf("model pin %0d", k), ref_op(dv_a[k], dv_b[k], dv_o[k]), dv_e[k]);

        strict = '0;
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("reset");
        mon_en = 1'b1;

        for (int i = 0; i < N; i++) begin
            nb[i] = 1;
            sa[i][0] = dv_a[i];
            sb[i][0] = dv_b[i];
            sop[i][0] = dv_o[i];
        end
        run_phase(0, 0, 4'b1111, 40);

        for (int i = 0; i < N; i++) begin
            nb[i] = 3;
            for (int j = 0; j < 3; j++) begin
                sa[i][j] = dv_a[4 + i + 4 * j];
                sb[i][j] = dv_b[4 + i + 4 * j];
                sop[i][j] = dv_o[4 + i + 4 * j];
            end
        end
        run_phase(0, 0, 4'b1111, 40);

        load_random(8);
        run_phase(2, 0, 4'b1011, 80);

        load_random(60);
        run_phase(1, 20, 4'b0000, 2000);

        load_random(2);
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                vin[d] = '1;
                for (int i = 0; i < N; i++) begin
                    a_fl[d][i*16 +: 16] = sa[i][j];
                    b_fl[d][i*16 +: 16] = sb[i][j];
                    op[d][i] = sop[i][j];
                end
            end
        end
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midreset");
        repeat (10) @(posedge clk);

        load_random(40);
        run_phase(1, 30, 4'b0000, 2000);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
